sram_1rw_req_ctrl: RTL and testbench

- Upstream request controller for a 1rw SRAM macro (clk0/csb0/web0/addr0/din0/dout0 interface, 32x128 default).
- Converts a valid/ready command stream into registered macro strobes.
- Captures dout0 after the fixed read latency into an in-order response FIFO with valid/ready backpressure.
- Read credits guarantee the response FIFO never overflows.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_rsp_fifo.sv | 68 ++++++
 rtl/sram_1rw_req_ctrl.sv | 124 ++++++++++++
 tb/tb_sram_1rw_req_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared defaults, the command record and sizing helpers for the 1rw SRAM request controller.
// The optional SRAM_CTRL_PERF_CNT_EN build adds read/write counters in the top.
package sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_RSP_DEPTH  = 4;

  // Command record at the default macro geometry (32x128).
  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } sram_cmd_t;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Show-ahead response FIFO: the head entry is visible whenever count_o is non-zero.
// Pointers wrap modulo DEPTH, so any depth (not only powers of two) is supported.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_RSP_DEPTH,
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Read credits upstream make a push into a full FIFO impossible.
  push_when_full_a : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full));

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Request controller for a 1rw SRAM macro: registered macro strobes, fixed-latency read capture
// into a credit-protected response FIFO. Define SRAM_CTRL_PERF_CNT_EN to add rd_cnt/wr_cnt.
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  busy
`ifdef SRAM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
`endif
);

  localparam int CW = cnt_width(RSP_DEPTH);

  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic [RD_LAT-1:0]     rd_pipe_q, rd_pipe_d;
  logic [CW-1:0]         rd_inflight, fifo_count;
  logic [CW:0]           credit_used;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  accept, fifo_pop;

  // Every accepted command reserves a slot: reads in flight plus stored responses never exceed depth.
  always_comb begin
    rd_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) rd_inflight = rd_inflight + CW'(rd_pipe_q[i]);
  end

  assign credit_used = {1'b0, rd_inflight} + {1'b0, fifo_count};
  assign cmd_ready   = ~rst0 && (credit_used < (CW+1)'(RSP_DEPTH));
  assign accept      = cmd_valid & cmd_ready;

  always_comb begin
    csb0_d       = ~accept;
    web0_d       = accept ? ~cmd_we : 1'b1;
    addr0_d      = accept ? cmd_addr : addr0_q;
    din0_d       = (accept && cmd_we) ? cmd_wdata : din0_q;
    rd_pipe_d    = '0;
    rd_pipe_d[0] = accept & ~cmd_we;
    for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      csb0_q    <= 1'b1;
      web0_q    <= 1'b1;
      addr0_q   <= '0;
      din0_q    <= '0;
      rd_pipe_q <= '0;
    end else begin
      csb0_q    <= csb0_d;
      web0_q    <= web0_d;
      addr0_q   <= addr0_d;
      din0_q    <= din0_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  assign csb0  = csb0_q;
  assign web0  = web0_q;
  assign addr0 = addr0_q;
  assign din0  = din0_q;

  // The oldest pipeline stage marks the edge at which dout0 holds that read's data.
  sram_rsp_fifo #(
    .DEPTH(RSP_DEPTH),
    .WIDTH(DATA_WIDTH),
    .CW   (CW)
  ) u_rsp_fifo (
    .clk_i      (clk0),
    .rst_i      (rst0),
    .push_i     (rd_pipe_q[RD_LAT-1]),
    .push_data_i(dout0),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_rdata = rsp_valid ? fifo_head : '0;
  assign fifo_pop  = rsp_valid & rsp_ready;
  assign busy      = ~csb0_q | (rd_inflight != '0) | (fifo_count != '0);

`ifdef SRAM_CTRL_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_q + 32'(accept & ~cmd_we);
      wr_cnt_q <= wr_cnt_q + 32'(accept & cmd_we);
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Self-checking bench for sram_1rw_req_ctrl with a behavioural 1rw macro and a response scoreboard.
// Counter checks run when SRAM_CTRL_PERF_CNT_EN is defined.
module tb_sram_1rw_req_ctrl;
  import sram_ctrl_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ADDR_WIDTH;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr, addr0;
  logic [DW-1:0] cmd_wdata, rsp_rdata, din0, dout0;
  logic          rsp_valid, rsp_ready, csb0, web0, busy;
`ifdef SRAM_CTRL_PERF_CNT_EN
  logic [31:0]   rd_cnt, wr_cnt;
`endif

  sram_1rw_req_ctrl dut (
    .clk0     (clk0),
    .rst0     (rst0),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .csb0     (csb0),
    .web0     (web0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0),
    .busy     (busy)
`ifdef SRAM_CTRL_PERF_CNT_EN
    ,
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
`endif
  );

  always #5 clk0 = ~clk0;

  // Behavioural macro: captures strobes on the rising edge, dout0 valid one edge later.
  logic [DW-1:0] macro_mem [2**AW];
  always @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) macro_mem[addr0] <= din0;
      else       dout0 <= macro_mem[addr0];
    end
  end

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] last_din = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic sram_cmd_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return '{we: 1'b1, addr: a, wdata: d};
  endfunction

  function automatic sram_cmd_t rd(input logic [AW-1:0] a);
    return '{we: 1'b0, addr: a, wdata: '0};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_cmd(input sram_cmd_t c, output int stalls);
    bit accepted = 0;
    stalls    = 0;
    cmd_valid = 1'b1;
    cmd_we    = c.we;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    while (!accepted && stalls < 50) begin
      @(negedge clk0);
      if (cmd_ready) begin
        accepted = 1;
        if (c.we) begin
          ref_mem[c.addr] = c.wdata;
          last_din        = c.wdata;
        end else begin
          exp_q.push_back(ref_mem[c.addr]);
        end
      end else begin
        stalls++;
      end
      @(posedge clk0);
      #1;
    end
    cmd_valid = 1'b0;
    if (!accepted) begin
      check("cmd_accept_timeout", 0, 1);
    end else begin
      check("csb0_active", csb0, 0);
      check("web0_level", web0, !c.we);
      check("addr0_value", addr0, c.addr);
      check("din0_value", din0, last_din);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(posedge clk0);
      #1;
      n++;
    end
    check("drain_done", (exp_q.size() == 0 && !busy), 1);
  endtask

  // Response side of the scoreboard.
  always @(negedge clk0) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else                   check("rsp_data", rsp_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stalls;
    int total_stalls;
    int n_acc;
    bit saw_valid;
    logic [AW-1:0] a;

    rst0      = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk0);
    #1;
    check("rst_csb0", csb0, 1);
    check("rst_web0", web0, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    rst0 = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write then read the same address on the next cycle
    do_cmd(wr(7'h05, 32'hDEADBEEF), stalls);
    do_cmd(rd(7'h05), stalls);
    check("raw_valid_early0", rsp_valid, 0);
    @(posedge clk0); #1;
    check("raw_valid_early1", rsp_valid, 0);
    @(posedge clk0); #1;
    check("raw_valid_on_time", rsp_valid, 1);
    check("raw_rdata", rsp_rdata, 32'hDEADBEEF);
    check("idle_csb0", csb0, 1);
    check("idle_web0", web0, 1);
    check("idle_addr0_hold", addr0, 7'h05);
    drain();

    // Prefill then back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) do_cmd(wr(AW'(i), 32'h100 + i), stalls);
    total_stalls = 0;
    for (int i = 0; i < 8; i++) begin
      do_cmd(rd(AW'(i)), stalls);
      total_stalls += stalls;
    end
    check("b2b_read_stalls", total_stalls, 0);
    drain();

    // Backpressure: credits cap outstanding reads at the FIFO depth
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    a         = '0;
    n_acc     = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_addr = a;
      @(negedge clk0);
      if (cmd_ready) begin
        exp_q.push_back(ref_mem[a]);
        a++;
        n_acc++;
      end
      @(posedge clk0); #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepted", n_acc, DEF_RSP_DEPTH);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_head_valid", rsp_valid, 1);
    check("bp_head_data", rsp_rdata, 32'h100);
    rsp_ready = 1'b1;
    drain();
    check("bp_cmd_ready_back", cmd_ready, 1);

    // Reset with reads in flight: results are discarded, write survives
    do_cmd(wr(7'h10, 32'hA5A5A5A5), stalls);
    do_cmd(rd(7'h10), stalls);
    do_cmd(rd(7'h10), stalls);
    rst0 = 1'b1;
    @(posedge clk0); #1;
    exp_q.delete();
    last_din = '0;
    check("midrst_busy", busy, 0);
    rst0 = 1'b0;
    saw_valid = 0;
    repeat (6) begin
      @(negedge clk0);
      saw_valid |= rsp_valid;
    end
    @(posedge clk0); #1;
    check("midrst_no_rsp", saw_valid, 0);
    check("midrst_rdata_zero", rsp_rdata, 0);
    do_cmd(rd(7'h10), stalls);
    drain();

`ifdef SRAM_CTRL_PERF_CNT_EN
    rst0 = 1'b1;
    @(posedge clk0); #1;
    rst0 = 1'b0;
    last_din = '0;
    for (int i = 0; i < 3; i++) do_cmd(wr(AW'(32 + i), 32'h200 + i), stalls);
    for (int i = 0; i < 5; i++) do_cmd(rd(AW'(32 + (i % 3))), stalls);
    drain();
    check("perf_wr_cnt", wr_cnt, 3);
    check("perf_rd_cnt", rd_cnt, 5);
    rst0 = 1'b1;
    @(posedge clk0); #1;
    check("perf_wr_cnt_rst", wr_cnt, 0);
    check("perf_rd_cnt_rst", rd_cnt, 0);
    rst0 = 1'b0;
`endif

    repeat (2) @(posedge clk0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
